// File: rtl/vga_tile_buffer.sv
`timescale 1ns/1ps
// vga_tile_buffer: double-buffered tile-colour store.
// The VGA side reads the front bank. The CPU reads and writes the back bank.
// Bank swaps commit only at the vsync falling edge. After each swap the new
// front bank is copied into the new back bank, so the CPU edits the frame on
// display incrementally instead of starting from stale data.
module vga_tile_buffer #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int COPY_N = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_color,
    input  logic              vsync,
    input  logic              cpu_we,
    input  logic              cpu_re,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              swap_req,
    output logic              swap_pending,
    output logic              front_sel
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_COPY = 2'd2
    } state_t;

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(COPY_N - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    // Both banks in one array; the MSB of the index selects the bank.
    logic [DATA_W-1:0] mem_q [0:2*DEPTH-1];

    state_t            state_q,     state_d;
    logic              front_sel_q, front_sel_d;
    logic [ADDR_W-1:0] idx_q,       idx_d;
    logic              rereq_q,     rereq_d;
    logic              vsync_dly_q;
    logic              cpu_ready_q, cpu_ready_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] vga_color_q, vga_color_d;

    logic              vs_fall;
    logic              in_copy;
    logic              back_sel;
    logic              cpu_accept;
    logic              mem_we;
    logic [ADDR_W:0]   mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // vsync is already synchronous to clk, so a single delay stage suffices.
    assign vs_fall    = vsync_dly_q & ~vsync;
    assign in_copy    = (state_q == ST_COPY);
    assign back_sel   = ~front_sel_q;
    // The CPU is held off during the copy and on the commit edge, so its
    // write never collides with the copy engine or a bank flip.
    assign cpu_accept = (cpu_we | cpu_re) & ~cpu_ready_q & ~in_copy & ~vs_fall;

    // Select the single back-bank write source: copy engine or CPU.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        mem_we    = 1'b0;
        mem_waddr = {back_sel, cpu_addr};
        mem_wdata = cpu_wdata;
        if (in_copy) begin
            mem_we    = 1'b1;
            mem_waddr = {back_sel, idx_q};
            mem_wdata = mem_q[{front_sel_q, idx_q}];
        end else if (cpu_accept && cpu_we) begin
            mem_we = 1'b1;
        end
    end

    // Bank storage write port.
    // NOTE: the RAM has no reset; its contents are defined only by writes, which lets it map to memory.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Read-port and CPU handshake next-state values.
    always_comb begin
        vga_color_d = mem_q[{front_sel_q, vga_addr}];
        cpu_ready_d = cpu_accept;
        cpu_rdata_d = cpu_rdata_q;
        // A combined write+read request performs the write only.
        if (cpu_accept && cpu_re && !cpu_we) begin
            cpu_rdata_d = mem_q[{back_sel, cpu_addr}];
        end
    end

    // Swap FSM: wait for a request, commit at vsync fall, then copy front to back.
    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        idx_d       = idx_q;
        rereq_d     = rereq_q;
        case (state_q)
            ST_IDLE: begin
                if (swap_req) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                // Extra swap_req pulses here merge into the pending one.
                if (vs_fall) begin
                    front_sel_d = ~front_sel_q;
                    idx_d       = '0;
                    rereq_d     = 1'b0;
                    state_d     = ST_COPY;
                end
            end
            ST_COPY: begin
                idx_d = idx_q + IDX_ONE;
                if (swap_req) begin
                    rereq_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = (rereq_q || swap_req) ? ST_PEND : ST_IDLE;
                    rereq_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers; reset aborts any copy in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            front_sel_q <= 1'b0;
            idx_q       <= '0;
            rereq_q     <= 1'b0;
            vsync_dly_q <= 1'b1;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            vga_color_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            idx_q       <= idx_d;
            rereq_q     <= rereq_d;
            vsync_dly_q <= vsync;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            vga_color_q <= vga_color_d;
        end
    end

    assign vga_color    = vga_color_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign cpu_ready    = cpu_ready_q;
    assign front_sel    = front_sel_q;
    assign swap_pending = (state_q == ST_PEND) || (in_copy && rereq_q);

endmodule

// File: tb/tb_vga_tile_buffer.sv
`timescale 1ns/1ps
// Testbench for vga_tile_buffer: randomized data checked against a model of
// two banks plus a front pointer; a committed swap flips the pointer and
// makes the back bank a copy of the new front.
module tb_vga_tile_buffer;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int COPY_N = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_color;
    logic              vsync;
    logic              cpu_we;
    logic              cpu_re;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              swap_req;
    logic              swap_pending;
    logic              front_sel;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] mdl [2][64];
    logic              m_front;

    vga_tile_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .COPY_N(COPY_N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vga_addr     (vga_addr),
        .vga_color    (vga_color),
        .vsync        (vsync),
        .cpu_we       (cpu_we),
        .cpu_re       (cpu_re),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_ready    (cpu_ready),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .front_sel    (front_sel)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model of a committed swap: flip front, back becomes a copy of it.
    task automatic m_commit();
        m_front = ~m_front;
        for (int i = 0; i < 64; i++) mdl[~m_front][i] = mdl[m_front][i];
    endtask

    // Drive one CPU request and hold it until cpu_ready (bounded wait).
    task automatic cpu_op(input logic we, input logic re, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, output int cycles);
        cpu_we = we; cpu_re = re; cpu_addr = addr; cpu_wdata = wdata;
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (cpu_ready !== 1'b1 && cycles < 200);
        checks++;
        if (cpu_ready !== 1'b1) begin
            errors++;
            $display("FAIL cpu_op_timeout addr=%0d ready=%b cycles=%0d", addr, cpu_ready, cycles);
        end
        cpu_we = 1'b0; cpu_re = 1'b0;
        if (we) mdl[~m_front][addr] = wdata;
    endtask

    task automatic swap_and_fall();
        swap_req = 1'b1; step(); swap_req = 1'b0;
        vsync = 1'b0; step(); vsync = 1'b1;
        m_commit();
    endtask

    task automatic wait_copy();
        repeat (COPY_N + 2) step();
    endtask

    // Fill the back bank with random data and swap, so both banks are defined.
    task automatic init_fill();
        int cyc;
        step();
        for (int i = 0; i < 64; i++) begin
            cpu_op(1'b1, 1'b0, ADDR_W'(i), DATA_W'($urandom), cyc);
            step();
        end
        swap_and_fall();
        wait_copy();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vsync = 1'b1; vga_addr = '0; cpu_we = 1'b0; cpu_re = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; swap_req = 1'b0; m_front = 1'b0;
        repeat (3) step();
        checks += 5;
        if (vga_color !== 8'h00) begin errors++; $display("FAIL reset_vga_color got=%h exp=00", vga_color); end
        if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_cpu_rdata got=%h exp=00", cpu_rdata); end
        if (cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_cpu_ready got=%b exp=0", cpu_ready); end
        if (swap_pending !== 1'b0) begin errors++; $display("FAIL reset_swap_pending got=%b exp=0", swap_pending); end
        if (front_sel !== 1'b0) begin errors++; $display("FAIL reset_front_sel got=%b exp=0", front_sel); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_init();
        init_fill();
        checks += 2;
        if (front_sel !== m_front) begin errors++; $display("FAIL init_front_sel got=%b exp=%b", front_sel, m_front); end
        if (swap_pending !== 1'b0) begin errors++; $display("FAIL init_swap_pending got=%b exp=0", swap_pending); end
    endtask

    task automatic test_vga_random();
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < 40; i++) begin
            a = ADDR_W'($urandom_range(0, 63));
            vga_addr = a;
            step();
            checks++;
            if (vga_color !== mdl[m_front][a])
                begin errors++; $display("FAIL vga_read addr=%0d got=%h exp=%h", a, vga_color, mdl[m_front][a]); end
        end
    endtask

    task automatic test_cpu_rw();
        int cyc;
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < 20; i++) begin
            a = ADDR_W'($urandom_range(0, 63));
            cpu_op(1'b1, 1'b0, a, DATA_W'($urandom), cyc);
            checks++;
            if (cyc != 1) begin errors++; $display("FAIL cpu_write_latency got=%0d exp=1", cyc); end
            step();
            a = ADDR_W'($urandom_range(0, 63));
            cpu_op(1'b0, 1'b1, a, '0, cyc);
            checks += 2;
            if (cyc != 1) begin errors++; $display("FAIL cpu_read_latency got=%0d exp=1", cyc); end
            if (cpu_rdata !== mdl[~m_front][a])
                begin errors++; $display("FAIL cpu_read addr=%0d got=%h exp=%h", a, cpu_rdata, mdl[~m_front][a]); end
            step();
        end
    endtask

    task automatic test_swap();
        int cyc;
        logic old_front;
        logic [ADDR_W-1:0] prev;
        cpu_op(1'b1, 1'b0, 6'd5, 8'hE0, cyc);
        step();
        vga_addr = 6'd5;
        step();
        checks++;
        if (vga_color !== mdl[m_front][5])
            begin errors++; $display("FAIL swap_vga_before got=%h exp=%h", vga_color, mdl[m_front][5]); end
        cpu_op(1'b0, 1'b1, 6'd5, '0, cyc);
        checks++;
        if (cpu_rdata !== 8'hE0) begin errors++; $display("FAIL swap_cpu_read_back got=%h exp=e0", cpu_rdata); end
        step();
        old_front = m_front;
        swap_req = 1'b1; step(); swap_req = 1'b0;
        checks += 2;
        if (swap_pending !== 1'b1) begin errors++; $display("FAIL swap_pending_set got=%b exp=1", swap_pending); end
        if (front_sel !== old_front) begin errors++; $display("FAIL swap_no_early_flip got=%b exp=%b", front_sel, old_front); end
        vsync = 1'b0; step(); vsync = 1'b1;
        m_commit();
        checks++;
        if (front_sel !== ~old_front) begin errors++; $display("FAIL swap_flip got=%b exp=%b", front_sel, ~old_front); end
        // Read issued on the first copy cycle stalls until the copy ends.
        cpu_re = 1'b1; cpu_addr = 6'd5;
        prev = 6'd5; vga_addr = prev;
        cyc = 0;
        do begin
            step();
            cyc++;
            checks++;
            if (vga_color !== mdl[m_front][prev])
                begin errors++; $display("FAIL copy_vga_read addr=%0d got=%h exp=%h", prev, vga_color, mdl[m_front][prev]); end
            prev = ADDR_W'($urandom_range(0, 63));
            vga_addr = prev;
        end while (cpu_ready !== 1'b1 && cyc < 200);
        cpu_re = 1'b0;
        checks += 2;
        if (cyc != COPY_N + 1) begin errors++; $display("FAIL copy_stall_cycles got=%0d exp=%0d", cyc, COPY_N + 1); end
        if (cpu_rdata !== 8'hE0) begin errors++; $display("FAIL copy_read_after got=%h exp=e0", cpu_rdata); end
        step();
    endtask

    task automatic test_merge();
        swap_req = 1'b1; step(); swap_req = 1'b0; step();
        swap_req = 1'b1; step(); swap_req = 1'b0;
        checks++;
        if (swap_pending !== 1'b1) begin errors++; $display("FAIL merge_pending got=%b exp=1", swap_pending); end
        vsync = 1'b0; step(); vsync = 1'b1;
        m_commit();
        wait_copy();
        checks += 2;
        if (front_sel !== m_front) begin errors++; $display("FAIL merge_single_flip got=%b exp=%b", front_sel, m_front); end
        if (swap_pending !== 1'b0) begin errors++; $display("FAIL merge_pending_clear got=%b exp=0", swap_pending); end
    endtask

    task automatic test_rereq();
        swap_and_fall();
        repeat (5) step();
        swap_req = 1'b1; step(); swap_req = 1'b0;
        checks++;
        if (swap_pending !== 1'b1) begin errors++; $display("FAIL rereq_pending_copy got=%b exp=1", swap_pending); end
        wait_copy();
        checks += 2;
        if (swap_pending !== 1'b1) begin errors++; $display("FAIL rereq_pending_after got=%b exp=1", swap_pending); end
        if (front_sel !== m_front) begin errors++; $display("FAIL rereq_no_flip got=%b exp=%b", front_sel, m_front); end
        vsync = 1'b0; step(); vsync = 1'b1;
        m_commit();
        checks++;
        if (front_sel !== m_front) begin errors++; $display("FAIL rereq_second_flip got=%b exp=%b", front_sel, m_front); end
        wait_copy();
        checks++;
        if (swap_pending !== 1'b0) begin errors++; $display("FAIL rereq_pending_clear got=%b exp=0", swap_pending); end
    endtask

    task automatic test_vsync_idle();
        vsync = 1'b0; step(); vsync = 1'b1; step();
        checks += 2;
        if (front_sel !== m_front) begin errors++; $display("FAIL idle_fall_flip got=%b exp=%b", front_sel, m_front); end
        if (swap_pending !== 1'b0) begin errors++; $display("FAIL idle_fall_pending got=%b exp=0", swap_pending); end
        swap_req = 1'b1; vsync = 1'b0; step(); swap_req = 1'b0; vsync = 1'b1;
        checks += 2;
        if (swap_pending !== 1'b1) begin errors++; $display("FAIL same_cycle_pending got=%b exp=1", swap_pending); end
        if (front_sel !== m_front) begin errors++; $display("FAIL same_cycle_no_flip got=%b exp=%b", front_sel, m_front); end
        repeat (3) step();
        vsync = 1'b0; step(); vsync = 1'b1;
        m_commit();
        checks++;
        if (front_sel !== m_front) begin errors++; $display("FAIL same_cycle_next_flip got=%b exp=%b", front_sel, m_front); end
        wait_copy();
    endtask

    task automatic test_we_re_both();
        int cyc;
        logic [DATA_W-1:0] v, d;
        v = mdl[~m_front][3] ^ 8'hFF;
        d = v ^ 8'h5A;
        cpu_op(1'b1, 1'b0, 6'd10, v, cyc); step();
        cpu_op(1'b0, 1'b1, 6'd10, '0, cyc); step();
        cpu_we = 1'b1; cpu_re = 1'b1; cpu_addr = 6'd3; cpu_wdata = d;
        step();
        checks += 2;
        if (cpu_ready !== 1'b1) begin errors++; $display("FAIL both_ready got=%b exp=1", cpu_ready); end
        if (cpu_rdata !== v) begin errors++; $display("FAIL both_rdata_kept got=%h exp=%h", cpu_rdata, v); end
        step();
        checks++;
        if (cpu_ready !== 1'b0) begin errors++; $display("FAIL both_single_pulse got=%b exp=0", cpu_ready); end
        cpu_we = 1'b0; cpu_re = 1'b0;
        mdl[~m_front][3] = d;
        step();
        cpu_op(1'b0, 1'b1, 6'd3, '0, cyc);
        checks++;
        if (cpu_rdata !== d) begin errors++; $display("FAIL both_written got=%h exp=%h", cpu_rdata, d); end
        step();
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [ADDR_W-1:0] a;
        logic is_wr;
        step();
        for (int i = 0; i < 40; i++) begin
            a = ADDR_W'($urandom_range(0, 63));
            is_wr = 1'($urandom_range(0, 1));
            cpu_op(is_wr, ~is_wr, a, DATA_W'($urandom), cyc);
            checks++;
            if (cyc != ((i == 0) ? 1 : 2))
                begin errors++; $display("FAIL b2b_latency op=%0d got=%0d exp=%0d", i, cyc, (i == 0) ? 1 : 2); end
            if (!is_wr) begin
                checks++;
                if (cpu_rdata !== mdl[~m_front][a])
                    begin errors++; $display("FAIL b2b_read addr=%0d got=%h exp=%h", a, cpu_rdata, mdl[~m_front][a]); end
            end
        end
        step();
    endtask

    task automatic test_reset_mid_copy();
        int cyc;
        swap_and_fall();
        checks++;
        if (front_sel !== m_front) begin errors++; $display("FAIL rst_copy_flip got=%b exp=%b", front_sel, m_front); end
        vga_addr = 6'd7;
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (front_sel !== 1'b0) begin errors++; $display("FAIL rst_copy_front got=%b exp=0", front_sel); end
        if (cpu_ready !== 1'b0) begin errors++; $display("FAIL rst_copy_ready got=%b exp=0", cpu_ready); end
        if (vga_color !== 8'h00) begin errors++; $display("FAIL rst_copy_vga got=%h exp=00", vga_color); end
        if (swap_pending !== 1'b0) begin errors++; $display("FAIL rst_copy_pending got=%b exp=0", swap_pending); end
        if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL rst_copy_rdata got=%h exp=00", cpu_rdata); end
        step();
        rst_n = 1'b1;
        m_front = 1'b0;
        step();
        // An op completing in one cycle shows the FSM is no longer copying.
        cpu_op(1'b0, 1'b1, 6'd0, '0, cyc);
        checks++;
        if (cyc != 1) begin errors++; $display("FAIL rst_copy_fsm_idle latency got=%0d exp=1", cyc); end
        init_fill();
        checks++;
        if (front_sel !== m_front) begin errors++; $display("FAIL rst_refill_front got=%b exp=%b", front_sel, m_front); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_vga_random();
        test_cpu_rw();
        test_swap();
        test_merge();
        test_rereq();
        test_vsync_idle();
        test_we_re_both();
        test_back_to_back();
        test_reset_mid_copy();
        test_vga_random();
        test_cpu_rw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
